prog_seq: RTL and testbench

PROG_SEQ -- requirements
Module: prog_seq

---
 rtl/prog_seq_pkg.sv | 29 ++
 rtl/prog_seq_cycle_ctr.sv | 28 ++
 rtl/prog_seq.sv | 127 ++++++++++++
 tb/tb_prog_seq.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/prog_seq_pkg.sv
// ----------------------------------------------------------------------------
// prog_seq_pkg
// Shared definitions for the program sequencer: the FSM state type, the
// default PC width, and the start/end address table of the four programs.
// Program n occupies addresses START_ADDR[n] .. END_ADDR[n] inclusive.
// ----------------------------------------------------------------------------
package prog_seq_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    localparam int PW_DEFAULT = 10;

    localparam logic [15:0] START_ADDR [4] = '{16'd0,  16'd64,  16'd128, 16'd192};
    localparam logic [15:0] END_ADDR   [4] = '{16'd63, 16'd127, 16'd191, 16'd255};

    function automatic logic [15:0] start_addr(input logic [1:0] sel);
        return START_ADDR[sel];
    endfunction

    function automatic logic [15:0] end_addr(input logic [1:0] sel);
        return END_ADDR[sel];
    endfunction

endpackage

// File: rtl/prog_seq_cycle_ctr.sv
// ----------------------------------------------------------------------------
// cycle_ctr
// 16-bit saturating event counter with synchronous clear.
// Ports:
//   CLK  in   clock
//   clr  in   synchronous clear (wins over en)
//   en   in   count enable, one increment per enabled cycle
//   cnt  out  current count, sticks at 16'hFFFF
// ----------------------------------------------------------------------------
module cycle_ctr (
    input  logic        CLK,
    input  logic        clr,
    input  logic        en,
    output logic [15:0] cnt
);

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    always_ff @(posedge CLK) begin
        if (clr)
            cnt <= '0;
        else if (en)
            cnt <= sat_inc(cnt);
    end

endmodule

// File: rtl/prog_seq.sv
// ----------------------------------------------------------------------------
// prog_seq
// Program sequencer steering an external PC register: launches one of four
// fixed programs, follows decoded branches, and stops on a halt instruction
// or when the PC reaches the program's last address.
// Optional feature macro: CYCLE_COUNT_EN adds the 'cycles' output, the count
// of RUN cycles of the last/current program.
// Ports:
//   CLK         in   clock
//   init        in   synchronous active-high reset
//   start       in   launch request (honoured in IDLE and DONE only)
//   prog_sel    in   program index, captured when start is accepted
//   pc_in       in   current PC value
//   branch_abs  in   unconditional jump
//   branch_z    in   jump if ALU_zero
//   ALU_zero    in   ALU zero flag
//   br_target   in   jump destination
//   halt_instr  in   halt instruction decoded
//   pc_init     out  PC register init (mirrors init)
//   pc_halt     out  PC register freeze
//   pc_branch   out  PC register load-target strobe
//   pc_target   out  PC register target (0 when pc_branch is low)
//   busy        out  in LOAD or RUN
//   done        out  in DONE
//   cycles      out  RUN-cycle count (CYCLE_COUNT_EN only)
// ----------------------------------------------------------------------------
import prog_seq_pkg::*;

module prog_seq #(
    parameter int PW = PW_DEFAULT
) (
    input  logic          CLK,
    input  logic          init,
    input  logic          start,
    input  logic [1:0]    prog_sel,
    input  logic [PW-1:0] pc_in,
    input  logic          branch_abs,
    input  logic          branch_z,
    input  logic          ALU_zero,
    input  logic [PW-1:0] br_target,
    input  logic          halt_instr,
    output logic          pc_init,
    output logic          pc_halt,
    output logic          pc_branch,
    output logic [PW-1:0] pc_target,
    output logic          busy,
    output logic          done
`ifdef CYCLE_COUNT_EN
    ,
    output logic [15:0]   cycles
`endif
);

    state_t     state;
    logic [1:0] sel_q;
    logic       start_acc;
    logic       run_end;
    logic       take_branch;

    // start is only honoured when no program is in flight
    assign start_acc   = start && (state == ST_IDLE || state == ST_DONE);
    assign run_end     = (state == ST_RUN) &&
                         (halt_instr || pc_in == PW'(end_addr(sel_q)));
    assign take_branch = branch_abs || (branch_z && ALU_zero);

    always_ff @(posedge CLK) begin
        if (init) begin
            state <= ST_IDLE;
            sel_q <= 2'd0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start_acc) begin
                        state <= ST_LOAD;
                        sel_q <= prog_sel;
                    end
                end
                ST_LOAD: state <= ST_RUN;
                ST_RUN:  if (run_end) state <= ST_DONE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Outputs: end condition beats branch, branch beats increment
    always_comb begin
        pc_init   = init;
        pc_halt   = 1'b1;
        pc_branch = 1'b0;
        pc_target = '0;
        busy      = 1'b0;
        done      = 1'b0;
        if (!init) begin
            case (state)
                ST_LOAD: begin
                    pc_halt   = 1'b0;
                    pc_branch = 1'b1;
                    pc_target = PW'(start_addr(sel_q));
                    busy      = 1'b1;
                end
                ST_RUN: begin
                    busy = 1'b1;
                    if (!run_end) begin
                        pc_halt = 1'b0;
                        if (take_branch) begin
                            pc_branch = 1'b1;
                            pc_target = br_target;
                        end
                    end
                end
                ST_DONE: done = 1'b1;
                default: ;
            endcase
        end
    end

`ifdef CYCLE_COUNT_EN
    // Cleared by reset and on entry to LOAD; counts every RUN cycle incl. the last
    cycle_ctr u_cycle_ctr (
        .CLK (CLK),
        .clr (init || start_acc),
        .en  (state == ST_RUN),
        .cnt (cycles)
    );
`endif

endmodule

// File: tb/tb_prog_seq.sv
// ----------------------------------------------------------------------------
// tb_prog_seq
// Scoreboard bench for prog_seq. The driver applies one input vector per
// cycle, predicts the sequencer outputs from a program-level model that also
// plays the role of the PC register, and queues the prediction; a monitor on
// the falling edge pops and compares against the DUT.
// ----------------------------------------------------------------------------
module tb_prog_seq;

    localparam int PW = 10;

    typedef struct packed {
        logic          init;
        logic          halt;
        logic          br;
        logic [PW-1:0] tgt;
        logic          busy;
        logic          done;
        logic [15:0]   cyc;
        logic          cyc_chk;
    } exp_t;

    logic          CLK = 1'b0;
    logic          init, start, branch_abs, branch_z, ALU_zero, halt_instr;
    logic [1:0]    prog_sel;
    logic [PW-1:0] pc_in, br_target;
    logic          pc_init, pc_halt, pc_branch, busy, done;
    logic [PW-1:0] pc_target;
`ifdef CYCLE_COUNT_EN
    logic [15:0]   cycles;
`endif

    always #5 CLK = ~CLK;

    prog_seq #(.PW(PW)) dut (
        .CLK        (CLK),
        .init       (init),
        .start      (start),
        .prog_sel   (prog_sel),
        .pc_in      (pc_in),
        .branch_abs (branch_abs),
        .branch_z   (branch_z),
        .ALU_zero   (ALU_zero),
        .br_target  (br_target),
        .halt_instr (halt_instr),
        .pc_init    (pc_init),
        .pc_halt    (pc_halt),
        .pc_branch  (pc_branch),
        .pc_target  (pc_target),
        .busy       (busy),
        .done       (done)
`ifdef CYCLE_COUNT_EN
        ,
        .cycles     (cycles)
`endif
    );

    exp_t expq[$];
    int   checks = 0;
    int   errors = 0;
    int   ncyc   = 0;

    // Program-level model: what the program is doing, plus the PC register
    bit m_loading, m_running, m_finished, m_cyc_known;
    int m_sel, m_pc, m_cyc;

    task automatic cyc(input bit i_init, input bit i_start, input int i_sel,
                       input bit i_babs, input bit i_bz, input bit i_az,
                       input int i_tgt, input bit i_halt);
        exp_t e;
        int   first, last;
        bit   endc;
        init = i_init; start = i_start; prog_sel = 2'(i_sel);
        branch_abs = i_babs; branch_z = i_bz; ALU_zero = i_az;
        br_target = PW'(i_tgt); halt_instr = i_halt; pc_in = PW'(m_pc);
        first = 64 * m_sel;
        last  = first + 63;
        endc  = 0;
        e = '0;
        e.init = i_init;
        e.halt = 1'b1;
        e.cyc = 16'(m_cyc);
        e.cyc_chk = !i_init && m_cyc_known;
        if (!i_init) begin
            if (m_loading) begin
                e.halt = 0; e.br = 1; e.tgt = PW'(first); e.busy = 1;
            end else if (m_running) begin
                e.busy = 1;
                endc = i_halt || (m_pc == last);
                if (!endc) begin
                    e.halt = 0;
                    if (i_babs || (i_bz && i_az)) begin
                        e.br = 1; e.tgt = PW'(i_tgt);
                    end
                end
            end else begin
                e.done = m_finished;
            end
        end
        expq.push_back(e);
        @(posedge CLK);
        ncyc++;
        if (i_init) begin
            m_loading = 0; m_running = 0; m_finished = 0;
            m_sel = 0; m_cyc = 0; m_pc = 0; m_cyc_known = 1;
        end else begin
            if (m_loading) begin
                m_loading = 0; m_running = 1;
            end else if (m_running) begin
                if (m_cyc < 65535) m_cyc++;
                if (endc) begin m_running = 0; m_finished = 1; end
            end else if (i_start) begin
                m_loading = 1; m_finished = 0; m_sel = i_sel; m_cyc = 0;
            end
            if (!e.halt) m_pc = e.br ? int'(e.tgt) : (m_pc + 1) % (1 << PW);
        end
        #1;
    endtask

    task automatic nop();
        cyc(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Run a program straight through (no branches) until it leaves RUN
    task automatic run_straight(input int bound);
        for (int k = 0; k < bound && (m_loading || m_running); k++) nop();
    endtask

    exp_t mon_e;
    bit   mon_bad;
    int   mon_cyc;
    always @(negedge CLK) begin
        if (expq.size() > 0) begin
            mon_e = expq.pop_front();
            mon_bad = (pc_init !== mon_e.init) || (pc_halt !== mon_e.halt) ||
                      (pc_branch !== mon_e.br) || (pc_target !== mon_e.tgt) ||
                      (busy !== mon_e.busy) || (done !== mon_e.done);
            mon_cyc = 0;
`ifdef CYCLE_COUNT_EN
            mon_cyc = int'(cycles);
            if (mon_e.cyc_chk && cycles !== mon_e.cyc) mon_bad = 1;
`endif
            checks++;
            if (mon_bad) begin
                errors++;
                $display("FAIL outputs@cycle%0d: got init=%b halt=%b br=%b tgt=%0d busy=%b done=%b cyc=%0d; want init=%b halt=%b br=%b tgt=%0d busy=%b done=%b cyc=%0d(chk=%b)",
                         ncyc, pc_init, pc_halt, pc_branch, pc_target, busy, done, mon_cyc,
                         mon_e.init, mon_e.halt, mon_e.br, mon_e.tgt, mon_e.busy, mon_e.done,
                         mon_e.cyc, mon_e.cyc_chk);
            end
        end
    end

    initial begin
        int first, steps;
        m_loading = 0; m_running = 0; m_finished = 0; m_cyc_known = 0;
        m_sel = 0; m_pc = 0; m_cyc = 0;
        init = 1; start = 0; prog_sel = 0; branch_abs = 0; branch_z = 0;
        ALU_zero = 0; br_target = '0; halt_instr = 0; pc_in = '0;
        @(posedge CLK); #1;

        // Reset, including a start that reset must override
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 2, 0, 0, 0, 0, 0);
        nop();

        // Program 1: LOAD to 64, conditional branch not taken then taken
        cyc(0, 1, 1, 0, 0, 0, 0, 0);
        nop();
        cyc(0, 0, 0, 0, 1, 0, 100, 0);
        cyc(0, 0, 0, 0, 1, 1, 100, 0);
        nop();
        cyc(0, 1, 2, 0, 0, 0, 0, 0);     // ignored while running
        nop();
        cyc(0, 0, 0, 1, 0, 0, 120, 1);   // halt beats branch
        nop(); nop();

        // DONE -> program 3, start pulse during RUN, then reset mid-run
        cyc(0, 1, 3, 0, 0, 0, 0, 0);
        nop(); nop();
        cyc(0, 1, 0, 0, 0, 0, 0, 0);
        nop(); nop();
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        nop(); nop();

        // Straight-line runs to each program's last address
        for (int s = 0; s < 4; s++) begin
            cyc(0, 1, s, 0, 0, 0, 0, 0);
            run_straight(200);
            nop(); nop();
        end

        // Reset asserted mid-RUN at PC 20
        cyc(0, 1, 0, 0, 0, 0, 0, 0);
        steps = 0;
        while ((m_loading || m_running) && m_pc != 20 && steps < 100) begin
            nop(); steps++;
        end
        cyc(1, 0, 0, 0, 0, 0, 0, 0);
        nop(); nop();

        // Randomized programs
        for (int p = 0; p < 30; p++) begin
            for (int w = $urandom_range(0, 2); w > 0; w--) nop();
            cyc(0, 1, $urandom_range(0, 3), 0, 0, 0, 0, 0);
            first = 64 * m_sel;
            for (int k = 0; k < 300 && (m_loading || m_running); k++) begin
                if ($urandom_range(0, 199) == 0) begin
                    cyc(1, 0, 0, 0, 0, 0, 0, 0);
                end else begin
                    cyc(0, $urandom_range(0, 9) == 0, $urandom_range(0, 3),
                        $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0,
                        $urandom_range(0, 1) == 1, first + $urandom_range(0, 63),
                        $urandom_range(0, 49) == 0);
                end
            end
            if (m_loading || m_running) cyc(1, 0, 0, 0, 0, 0, 0, 0);
            nop();
        end

        @(negedge CLK); #1;
        checks++;
        if (expq.size() != 0) begin
            errors++;
            $display("FAIL scoreboard-drain: got %0d entries left, want 0", expq.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
